// File: rtl/deadlock_mon_pkg.sv
// Shared constants and helpers for the dataflow deadlock monitors.
package deadlock_mon_pkg;

    localparam int DEADLOCK_DEFAULT_THRESHOLD = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/deadlock_persist_filter.sv
// Persistence filter: output rises once raw_in has been high for
// THRESHOLD consecutive rising edges, and falls on the first low sample.
module deadlock_persist_filter
    import deadlock_mon_pkg::*;
#(
    parameter int THRESHOLD = DEADLOCK_DEFAULT_THRESHOLD
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in,
    output logic filt_out
);

    localparam int CW = clog2(THRESHOLD + 1);
    localparam int W  = (CW < 1) ? 1 : CW;
    localparam logic [W:0] TH = (W + 1)'(THRESHOLD);

    generate
        if (THRESHOLD < 1) begin : g_bad_threshold
            $error("deadlock_persist_filter: THRESHOLD must be >= 1");
        end
    endgenerate

    logic [W-1:0] r_cnt;
    logic         r_out;
    logic [W:0]   w_next;
    logic         w_hit;

    assign w_next = {1'b0, r_cnt} + {{W{1'b0}}, 1'b1};
    assign w_hit  = (w_next >= TH);

    // Counter saturates at the threshold so a long stall never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (!raw_in) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else begin
            r_cnt <= w_hit ? TH[W-1:0] : w_next[W-1:0];
            r_out <= w_hit;
        end
    end

    assign filt_out = r_out;

endmodule

// File: rtl/deadlock_idx_monitor.sv
// Deadlock detector for dataflow region 0: folds AXI-Stream and
// sub-instance stall flags into one filtered, registered block flag.
module deadlock_idx_monitor
    import deadlock_mon_pkg::*;
#(
    parameter int NUM_AXIS        = 2,
    parameter int NUM_INST        = 1,
    parameter int BLOCK_THRESHOLD = DEADLOCK_DEFAULT_THRESHOLD
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic [NUM_INST-1:0] inst_block_sigs,
    output logic                block
);

    logic w_axis_stall;
    logic w_inst_stall;
    logic w_raw_stall;

    assign w_axis_stall = |axis_block_sigs;

    // All idle with nobody blocked is a finished region, not a deadlock.
    assign w_inst_stall = (&(inst_idle_sigs | inst_block_sigs))
                        & (|inst_block_sigs);

    assign w_raw_stall = w_axis_stall | w_inst_stall;

    deadlock_persist_filter #(
        .THRESHOLD (BLOCK_THRESHOLD)
    ) u_filt (
        .clock    (clock),
        .reset    (reset),
        .raw_in   (w_raw_stall),
        .filt_out (block)
    );

endmodule

// File: tb/tb_deadlock_idx_monitor.sv
// Directed bench: three monitor configurations driven in lockstep.
module tb_deadlock_idx_monitor;

    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] axis;
        logic [1:0] idle;
        logic [1:0] blk;
        logic       ea;
        logic       eb;
        logic       ec;
    } vec_t;

    logic       clock;
    logic       rst;
    logic [1:0] axis;
    logic [1:0] idle;
    logic [1:0] blk;
    logic       blk_a;
    logic       blk_b;
    logic       blk_c;

    int n_cmp;
    int n_fail;

    vec_t vecs[34];

    deadlock_idx_monitor #(
        .NUM_AXIS(2), .NUM_INST(1), .BLOCK_THRESHOLD(1)
    ) dut_a (
        .clock           (clock),
        .reset           (rst),
        .axis_block_sigs (axis),
        .inst_idle_sigs  (idle[0]),
        .inst_block_sigs (blk[0]),
        .block           (blk_a)
    );

    deadlock_idx_monitor #(
        .NUM_AXIS(2), .NUM_INST(2), .BLOCK_THRESHOLD(1)
    ) dut_b (
        .clock           (clock),
        .reset           (rst),
        .axis_block_sigs (axis),
        .inst_idle_sigs  (idle),
        .inst_block_sigs (blk),
        .block           (blk_b)
    );

    deadlock_idx_monitor #(
        .NUM_AXIS(2), .NUM_INST(1), .BLOCK_THRESHOLD(3)
    ) dut_c (
        .clock           (clock),
        .reset           (rst),
        .axis_block_sigs (axis),
        .inst_idle_sigs  (idle[0]),
        .inst_block_sigs (blk[0]),
        .block           (blk_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(string nm, logic r, logic [1:0] ax,
                                logic [1:0] id, logic [1:0] bk,
                                logic a, logic b, logic c);
        vec_t v;
        v.name = nm; v.rst = r; v.axis = ax; v.idle = id; v.blk = bk;
        v.ea = a; v.eb = b; v.ec = c;
        return v;
    endfunction

    task automatic chk(string nm, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic step(logic r, logic [1:0] ax,
                        logic [1:0] id, logic [1:0] bk);
        rst = r; axis = ax; idle = id; blk = bk;
        @(posedge clock);
        #1;
    endtask

    int rise_a, rise_b, rise_c;
    logic pa, pb, pc;

    task automatic edge_step(logic [1:0] ax);
        step(1'b0, ax, 2'b00, 2'b00);
        if (blk_a && !pa) rise_a++;
        if (blk_b && !pb) rise_b++;
        if (blk_c && !pc) rise_c++;
        pa = blk_a; pb = blk_b; pc = blk_c;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1; axis = 2'b11; idle = 2'b00; blk = 2'b00;

        vecs[0]  = mk("rst0",     1, 2'b11, 2'b00, 2'b00, 0, 0, 0);
        vecs[1]  = mk("rst1",     1, 2'b11, 2'b00, 2'b00, 0, 0, 0);
        vecs[2]  = mk("rst2",     1, 2'b11, 2'b00, 2'b00, 0, 0, 0);
        vecs[3]  = mk("rel",      0, 2'b11, 2'b00, 2'b00, 1, 1, 0);
        vecs[4]  = mk("clr0",     0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        vecs[5]  = mk("ax01_1",   0, 2'b01, 2'b00, 2'b00, 1, 1, 0);
        vecs[6]  = mk("ax01_2",   0, 2'b01, 2'b00, 2'b00, 1, 1, 0);
        vecs[7]  = mk("ax01_3",   0, 2'b01, 2'b00, 2'b00, 1, 1, 1);
        vecs[8]  = mk("ax01_4",   0, 2'b01, 2'b00, 2'b00, 1, 1, 1);
        vecs[9]  = mk("ax01_off", 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        vecs[10] = mk("ax10_1",   0, 2'b10, 2'b00, 2'b00, 1, 1, 0);
        vecs[11] = mk("ax10_2",   0, 2'b10, 2'b00, 2'b00, 1, 1, 0);
        vecs[12] = mk("ax10_3",   0, 2'b10, 2'b00, 2'b00, 1, 1, 1);
        vecs[13] = mk("ax10_4",   0, 2'b10, 2'b00, 2'b00, 1, 1, 1);
        vecs[14] = mk("ax10_off", 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        vecs[15] = mk("i01_b10",  0, 2'b00, 2'b01, 2'b10, 0, 1, 0);
        vecs[16] = mk("i11_b00",  0, 2'b00, 2'b11, 2'b00, 0, 0, 0);
        vecs[17] = mk("i00_b01",  0, 2'b00, 2'b00, 2'b01, 1, 0, 0);
        vecs[18] = mk("i00_b11",  0, 2'b00, 2'b00, 2'b11, 1, 1, 0);
        vecs[19] = mk("i00_b00",  0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        vecs[20] = mk("pat1",     0, 2'b01, 2'b00, 2'b00, 1, 1, 0);
        vecs[21] = mk("pat2",     0, 2'b01, 2'b00, 2'b00, 1, 1, 0);
        vecs[22] = mk("pat3_0",   0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        vecs[23] = mk("pat4",     0, 2'b01, 2'b00, 2'b00, 1, 1, 0);
        vecs[24] = mk("pat5",     0, 2'b01, 2'b00, 2'b00, 1, 1, 0);
        vecs[25] = mk("pat6",     0, 2'b01, 2'b00, 2'b00, 1, 1, 1);
        vecs[26] = mk("pat_off",  0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        vecs[27] = mk("mid1",     0, 2'b01, 2'b00, 2'b00, 1, 1, 0);
        vecs[28] = mk("mid2",     0, 2'b01, 2'b00, 2'b00, 1, 1, 0);
        vecs[29] = mk("mid_rst",  1, 2'b01, 2'b00, 2'b00, 0, 0, 0);
        vecs[30] = mk("post1",    0, 2'b01, 2'b00, 2'b00, 1, 1, 0);
        vecs[31] = mk("post2",    0, 2'b01, 2'b00, 2'b00, 1, 1, 0);
        vecs[32] = mk("post3",    0, 2'b01, 2'b00, 2'b00, 1, 1, 1);
        vecs[33] = mk("post_off", 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].axis, vecs[i].idle, vecs[i].blk);
            chk({vecs[i].name, "/a"}, blk_a, vecs[i].ea);
            chk({vecs[i].name, "/b"}, blk_b, vecs[i].eb);
            chk({vecs[i].name, "/c"}, blk_c, vecs[i].ec);
        end

        // Long stall: threshold-3 output must hold and never wrap.
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 2'b01, 2'b00, 2'b00);
            chk($sformatf("hold%0d/a", k), blk_a, 1'b1);
            chk($sformatf("hold%0d/c", k), blk_c, (k >= 2));
        end
        step(1'b0, 2'b00, 2'b00, 2'b00);
        chk("hold_off/c", blk_c, 1'b0);
        step(1'b0, 2'b00, 2'b00, 2'b00);

        rise_a = 0; rise_b = 0; rise_c = 0;
        pa = blk_a; pb = blk_b; pc = blk_c;
        for (int k = 0; k < 5; k++) edge_step(2'b10);
        for (int k = 0; k < 2; k++) edge_step(2'b00);
        for (int k = 0; k < 5; k++) edge_step(2'b01);
        for (int k = 0; k < 2; k++) edge_step(2'b00);
        n_cmp++;
        if (rise_a != 2) begin
            n_fail++;
            $display("FAIL rises/a: got %0d, expected 2", rise_a);
        end
        n_cmp++;
        if (rise_b != 2) begin
            n_fail++;
            $display("FAIL rises/b: got %0d, expected 2", rise_b);
        end
        n_cmp++;
        if (rise_c != 2) begin
            n_fail++;
            $display("FAIL rises/c: got %0d, expected 2", rise_c);
        end
        chk("final/c", blk_c, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
